// File: rtl/sonar_pkg.sv
// Shared widths, bus map, reset values and arithmetic helpers for the sonar datapath.
package sonar_pkg;

    localparam int unsigned ACC_W  = 16;
    localparam int unsigned PCM_W  = 12;
    localparam int unsigned COEF_W = 16;

    localparam logic [31:0] BASE_ADR = 32'h3000_0000;

    // Register byte offsets within the 256-byte window
    localparam logic [7:0] OFS_CTRL   = 8'h00;
    localparam logic [7:0] OFS_B0     = 8'h04;
    localparam logic [7:0] OFS_B1     = 8'h08;
    localparam logic [7:0] OFS_THRESH = 8'h0C;
    localparam logic [7:0] OFS_PCM    = 8'h10;
    localparam logic [7:0] OFS_FIR    = 8'h14;
    localparam logic [7:0] OFS_PEAK   = 8'h18;
    localparam logic [7:0] OFS_STATUS = 8'h1C;

    localparam logic [15:0]       CTRL_RST   = 16'h0001;
    localparam logic [COEF_W-1:0] B0_RST     = 16'h4000;
    localparam logic [COEF_W-1:0] B1_RST     = 16'h0000;
    localparam logic [15:0]       THRESH_RST = 16'h7FFF;

    // Clamp a 32-bit signed value into the 16-bit signed range
    function automatic logic [15:0] sat16(input logic signed [31:0] v);
        if (v > 32'sd32767) begin
            return 16'h7FFF;
        end else if (v < -32'sd32768) begin
            return 16'h8000;
        end
        return v[15:0];
    endfunction

    // Magnitude of a 16-bit signed value; -32768 clamps to 32767
    function automatic logic [15:0] abs16(input logic [15:0] v);
        if (v == 16'h8000) begin
            return 16'h7FFF;
        end else if (v[15]) begin
            return ~v + 16'd1;
        end
        return v;
    endfunction

endpackage

// File: rtl/sonar_on_chip_dp_cic3.sv
// Third-order CIC decimator: integrators run at the PDM strobe, combs at the PCM strobe.
module cic3_decimator
    import sonar_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             ce_pdm_i,
    input  logic             ce_pcm_i,
    input  logic             pdm_i,
    output logic [PCM_W-1:0] pcm_o,
    output logic             pcm_vld_o
);

    logic [ACC_W-1:0] x;
    logic [ACC_W-1:0] int1_q, int2_q, int3_q;
    logic [ACC_W-1:0] dly1_q, dly2_q, dly3_q;
    logic [ACC_W-1:0] c1, c2;
    logic [PCM_W-1:0] pcm_d, pcm_q;
    logic             borrow;
    logic             vld_q;

    // Comb cascade and floor(comb3 / 16) computed on the upper bits only; the borrow
    // from the low nibble makes this exactly the upper 12 bits of the full difference.
    always_comb begin
        x      = pdm_i ? ACC_W'(1) : '1;
        c1     = int3_q - dly1_q;
        c2     = c1 - dly2_q;
        borrow = (c2[ACC_W-PCM_W-1:0] < dly3_q[ACC_W-PCM_W-1:0]);
        pcm_d  = c2[ACC_W-1:ACC_W-PCM_W] - dly3_q[ACC_W-1:ACC_W-PCM_W] - PCM_W'(borrow);
    end

    // Integrator, comb delay and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            int1_q <= '0;
            int2_q <= '0;
            int3_q <= '0;
            dly1_q <= '0;
            dly2_q <= '0;
            dly3_q <= '0;
            pcm_q  <= '0;
            vld_q  <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (en_i && ce_pdm_i) begin
                int1_q <= int1_q + x;
                int2_q <= int2_q + int1_q;
                int3_q <= int3_q + int2_q;
            end
            if (en_i && ce_pcm_i) begin
                dly1_q <= int3_q;
                dly2_q <= c1;
                dly3_q <= c2;
                pcm_q  <= pcm_d;
                vld_q  <= 1'b1;
            end
        end
    end

    assign pcm_o     = pcm_q;
    assign pcm_vld_o = vld_q;

endmodule

// File: rtl/sonar_on_chip_dp.sv
// Sonar receive datapath top: CIC decimator, 2-tap FIR, threshold detect and bus registers.
module sonar_on_chip_dp
    import sonar_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [15:0] wbs_dat_i,
    input  logic        wbs_strb_i,
    output logic        wbs_ack_o,
    output logic [15:0] wbs_dat_o,
    input  logic        ce_pdm,
    input  logic        ce_pcm,
    input  logic        pdm_data_i,
    input  logic        mclear,
    output logic        cmp
);

    logic [15:0]       ctrl_q, thresh_q;
    logic [COEF_W-1:0] b0_q, b1_q;
    logic              ack_q;
    logic [15:0]       rdat_q, rdat_d;
    logic              hit, acc, wr;
    logic              en;

    logic [PCM_W-1:0]   pcm;
    logic               pcm_vld;
    logic [PCM_W-1:0]   pcm_prev_q;
    logic signed [31:0] b0_x, b1_x, pcm_x, prev_x, sum, sum_sh;
    logic [15:0]        y_d, y_q;
    logic               y_vld_q;
    logic [15:0]        mag;
    logic               cmp_q;
    logic [15:0]        peak_q;

    assign en  = ctrl_q[0];
    assign hit = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
    assign acc = wb_valid_i && hit && !ack_q;
    assign wr  = acc && wbs_strb_i;

    cic3_decimator u_cic (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .ce_pdm_i  (ce_pdm),
        .ce_pcm_i  (ce_pcm),
        .pdm_i     (pdm_data_i),
        .pcm_o     (pcm),
        .pcm_vld_o (pcm_vld)
    );

    // FIR product sum in 32 bits, floor shift back to Q0, then saturate
    always_comb begin
        b0_x   = {{16{b0_q[COEF_W-1]}}, b0_q};
        b1_x   = {{16{b1_q[COEF_W-1]}}, b1_q};
        pcm_x  = {{(32-PCM_W){pcm[PCM_W-1]}}, pcm};
        prev_x = {{(32-PCM_W){pcm_prev_q[PCM_W-1]}}, pcm_prev_q};
        sum    = b0_x * pcm_x + b1_x * prev_x;
        sum_sh = sum >>> 14;
        y_d    = sat16(sum_sh);
        mag    = abs16(y_q);
    end

    // Read mux; unmapped offsets read as zero
    always_comb begin
        rdat_d = '0;
        case (wbs_adr_i[7:0])
            OFS_CTRL:   rdat_d = ctrl_q;
            OFS_B0:     rdat_d = b0_q;
            OFS_B1:     rdat_d = b1_q;
            OFS_THRESH: rdat_d = thresh_q;
            OFS_PCM:    rdat_d = {{(16-PCM_W){pcm[PCM_W-1]}}, pcm};
            OFS_FIR:    rdat_d = y_q;
            OFS_PEAK:   rdat_d = peak_q;
            OFS_STATUS: rdat_d = {15'd0, cmp_q};
            default:    rdat_d = '0;
        endcase
    end

    // Bus handshake and writable registers; writes land on the same edge as ack
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= CTRL_RST;
            b0_q     <= B0_RST;
            b1_q     <= B1_RST;
            thresh_q <= THRESH_RST;
            ack_q    <= 1'b0;
            rdat_q   <= '0;
        end else begin
            ack_q  <= acc;
            rdat_q <= (acc && !wbs_strb_i) ? rdat_d : 16'd0;
            if (wr) begin
                case (wbs_adr_i[7:0])
                    OFS_CTRL:   ctrl_q   <= wbs_dat_i;
                    OFS_B0:     b0_q     <= wbs_dat_i;
                    OFS_B1:     b1_q     <= wbs_dat_i;
                    OFS_THRESH: thresh_q <= wbs_dat_i;
                    default:    ;
                endcase
            end
        end
    end

    // FIR stage: one clock after each decimated sample
    always_ff @(posedge clk) begin
        if (rst) begin
            pcm_prev_q <= '0;
            y_q        <= '0;
            y_vld_q    <= 1'b0;
        end else begin
            y_vld_q <= 1'b0;
            if (pcm_vld && en) begin
                pcm_prev_q <= pcm;
                y_q        <= y_d;
                y_vld_q    <= 1'b1;
            end
        end
    end

    // Detect stage: clear wins over a simultaneous set
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q  <= 1'b0;
            peak_q <= '0;
        end else if (mclear) begin
            cmp_q  <= 1'b0;
            peak_q <= '0;
        end else if (y_vld_q && en && (mag > thresh_q)) begin
            cmp_q <= 1'b1;
            if (mag > peak_q) begin
                peak_q <= mag;
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = rdat_q;
    assign cmp       = cmp_q;

endmodule

// File: tb/tb_sonar_on_chip_dp.sv
// Directed bench for the sonar datapath: bus map, CIC/FIR levels, detect and clear.
module tb_sonar_on_chip_dp;
    import sonar_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wb_valid_i = 1'b0;
    logic [31:0] wbs_adr_i = '0;
    logic [15:0] wbs_dat_i = '0;
    logic        wbs_strb_i = 1'b0;
    logic        wbs_ack_o;
    logic [15:0] wbs_dat_o;
    logic        ce_pdm = 1'b0;
    logic        ce_pcm = 1'b0;
    logic        pdm_data_i = 1'b0;
    logic        mclear = 1'b0;
    logic        cmp;

    int total = 0;
    int bad = 0;
    int mode = 2;  // 0 all-ones, 1 all-zeros, 2 alternating

    sonar_on_chip_dp dut (
        .clk        (clk),
        .rst        (rst),
        .wb_valid_i (wb_valid_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_strb_i (wbs_strb_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .ce_pdm     (ce_pdm),
        .ce_pcm     (ce_pcm),
        .pdm_data_i (pdm_data_i),
        .mclear     (mclear),
        .cmp        (cmp)
    );

    always #5 clk = ~clk;

    // Strobes: PDM every 2 clk, PCM every 50 clk (R = 25)
    initial begin
        int cyc = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            ce_pdm = (cyc % 2 == 0);
            ce_pcm = (cyc % 50 == 1);
            if (ce_pdm) begin
                if (mode == 0) pdm_data_i = 1'b1;
                else if (mode == 1) pdm_data_i = 1'b0;
                else pdm_data_i = ~pdm_data_i;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // One bus transaction; lat = cycles from valid to ack, -1 if none within 4
    task automatic bus(input logic [31:0] adr, input logic w, input logic [15:0] wd,
                       output logic [15:0] rd, output int lat);
        @(posedge clk);
        #1;
        wb_valid_i = 1'b1;
        wbs_adr_i  = adr;
        wbs_dat_i  = wd;
        wbs_strb_i = w;
        lat = -1;
        rd  = '0;
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk);
            #1;
            if (wbs_ack_o) begin
                lat = i;
                rd  = wbs_dat_o;
                break;
            end
        end
        wb_valid_i = 1'b0;
        wbs_strb_i = 1'b0;
    endtask

    task automatic wr(input logic [7:0] ofs, input logic [15:0] d);
        logic [15:0] rd;
        int lat;
        bus(BASE_ADR | 32'(ofs), 1'b1, d, rd, lat);
        check("wr_ack", 32'(lat), 32'd1);
    endtask

    task automatic rd_chk(input string tag, input logic [7:0] ofs, input logic [15:0] exp);
        logic [15:0] rd;
        int lat;
        bus(BASE_ADR | 32'(ofs), 1'b0, 16'd0, rd, lat);
        check(tag, {lat == 1 ? 16'd0 : 16'hDEAD, rd}, {16'd0, exp});
    endtask

    // Return at the clock edge on which the DUT samples ce_pcm high
    task automatic wait_pcm();
        for (int i = 0; i < 120; i++) begin
            @(posedge clk);
            if (ce_pcm) return;
        end
        check("pcm_strobe_seen", 32'd0, 32'd1);
    endtask

    task automatic wait_periods(input int n);
        repeat (n * 50) @(posedge clk);
    endtask

    initial begin
        logic [15:0] rd;
        int lat;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_cmp", 32'(cmp), 32'd0);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", 32'(wbs_dat_o), 32'd0);
        rd_chk("rst_ctrl", OFS_CTRL, 16'h0001);
        rd_chk("rst_b0", OFS_B0, 16'h4000);
        rd_chk("rst_b1", OFS_B1, 16'h0000);
        rd_chk("rst_thresh", OFS_THRESH, 16'h7FFF);
        rd_chk("rst_peak", OFS_PEAK, 16'h0000);
        rd_chk("rst_status", OFS_STATUS, 16'h0000);

        // Bus map
        wr(OFS_THRESH, 16'd1234);
        rd_chk("thresh_rw", OFS_THRESH, 16'd1234);
        @(posedge clk);
        #1;
        check("ack_pulse_gone", 32'(wbs_ack_o), 32'd0);
        check("dat_idle_zero", 32'(wbs_dat_o), 32'd0);
        rd_chk("unmapped_rd", 8'h40, 16'h0000);
        wr(OFS_PEAK, 16'h1234);
        rd_chk("ro_write_ignored", OFS_PEAK, 16'h0000);
        bus(32'h3000_010C, 1'b0, 16'd0, rd, lat);
        check("miss_no_ack", 32'(lat), 32'hFFFF_FFFF);
        wr(OFS_THRESH, 16'h7FFF);

        // Alternating PDM: near-zero output, no detect
        wait_periods(8);
        bus(BASE_ADR | 32'(OFS_PCM), 1'b0, 16'd0, rd, lat);
        check("alt_pcm_small", 32'(rd == 16'h0000 || rd == 16'hFFFF || rd == 16'h0001), 32'd1);
        check("alt_cmp", 32'(cmp), 32'd0);

        // All-ones: 25^3 / 16 floored
        mode = 0;
        wait_periods(8);
        rd_chk("ones_pcm", OFS_PCM, 16'd976);
        rd_chk("ones_fir", OFS_FIR, 16'd976);
        check("ones_cmp_default_thresh", 32'(cmp), 32'd0);

        // Half/half coefficients, low threshold
        wr(OFS_B0, 16'h2000);
        wr(OFS_B1, 16'h2000);
        wr(OFS_THRESH, 16'd500);
        wait_periods(3);
        rd_chk("half_fir", OFS_FIR, 16'd976);
        check("half_cmp", 32'(cmp), 32'd1);
        rd_chk("half_peak", OFS_PEAK, 16'd976);

        // mclear mid-period, then re-detect on next sample
        wait_pcm();
        repeat (10) @(posedge clk);
        #1 mclear = 1'b1;
        @(posedge clk);
        #1 mclear = 1'b0;
        check("mclear_cmp", 32'(cmp), 32'd0);
        wait_pcm();
        @(posedge clk);
        @(posedge clk);
        #1 check("redetect_cmp", 32'(cmp), 32'd1);

        // mclear on the very cycle detect would set
        wait_pcm();
        repeat (10) @(posedge clk);
        #1 mclear = 1'b1;
        @(posedge clk);
        #1 mclear = 1'b0;
        wait_pcm();
        @(posedge clk);
        #1 mclear = 1'b1;
        @(posedge clk);
        #1 mclear = 1'b0;
        check("collide_cmp", 32'(cmp), 32'd0);
        repeat (3) @(posedge clk);
        #1 check("collide_cmp_later", 32'(cmp), 32'd0);
        wait_pcm();
        @(posedge clk);
        @(posedge clk);
        #1 check("after_collide_cmp", 32'(cmp), 32'd1);

        // Disabled: pipeline holds while input flips
        wr(OFS_CTRL, 16'h0000);
        mode = 1;
        wait_periods(3);
        rd_chk("hold_fir", OFS_FIR, 16'd976);
        rd_chk("hold_pcm", OFS_PCM, 16'd976);
        check("hold_cmp", 32'(cmp), 32'd1);
        wr(OFS_CTRL, 16'h0001);

        // All-zeros
        wr(OFS_B0, 16'h4000);
        wr(OFS_B1, 16'h0000);
        wr(OFS_THRESH, 16'h0000);
        wait_periods(8);
        @(posedge clk);
        #1 mclear = 1'b1;
        @(posedge clk);
        #1 mclear = 1'b0;
        wait_periods(2);
        rd_chk("zeros_pcm", OFS_PCM, 16'hFC2F);
        rd_chk("zeros_fir", OFS_FIR, 16'hFC2F);
        rd_chk("zeros_peak", OFS_PEAK, 16'd977);
        rd_chk("zeros_status", OFS_STATUS, 16'h0001);

        // Reset mid-stream
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        check("midrst_cmp", 32'(cmp), 32'd0);
        rd_chk("midrst_peak", OFS_PEAK, 16'h0000);
        rd_chk("midrst_b0", OFS_B0, 16'h4000);
        rd_chk("midrst_thresh", OFS_THRESH, 16'h7FFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
